uart_tx_feeder: RTL and testbench

//   Byte buffer and sequencer directly upstream of the 8-bit UART transmitter.

---
 rtl/uart_tx_feeder.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus sequencer that hands one byte at a time to an
// 8-bit UART transmitter and waits for its done pulse before sending the next.
module uart_tx_feeder #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned CLK_PER_BIT = 5208,
   parameter int unsigned GAP_CYCLES  = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [7:0]             wr_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   tx_enable,
   output logic [7:0]             tx_data,
   input  logic                   tx_done,
   output logic                   busy
);

   localparam int unsigned PTR_W     = $clog2(DEPTH);
   localparam int unsigned CNT_W     = PTR_W + 1;
   // One full frame (start + 8 data + stop) plus margin for a frame already in flight
   localparam int unsigned GUARD_LEN = 10 * CLK_PER_BIT + 2;
   localparam int unsigned GUARD_W   = $clog2(GUARD_LEN);
   localparam int unsigned GAP_LAST  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam int unsigned GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [2:0] {
      ST_GUARD,
      ST_IDLE,
      ST_SEND,
      ST_WAIT,
      ST_GAP
   } state_t;

   state_t             state_q,     state_d;
   logic [7:0]         mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q,    wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q,    rd_ptr_d;
   logic [CNT_W-1:0]   count_q,     count_d;
   logic               overflow_q,  overflow_d;
   logic               tx_enable_q, tx_enable_d;
   logic [7:0]         tx_data_q,   tx_data_d;
   logic [GUARD_W-1:0] guard_cnt_q, guard_cnt_d;
   logic [GAP_W-1:0]   gap_cnt_q,   gap_cnt_d;

   logic               full_c;
   logic               push_c;
   logic               pop_c;

   // Occupancy decode; a pop on the same edge never frees room for a push
   assign full_c = (count_q == CNT_W'(DEPTH));
   assign push_c = wr_en && !full_c;
   assign pop_c  = (state_q == ST_IDLE) && (count_q != '0);

   // FIFO pointer, occupancy and sticky overflow next-state
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push_c) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (wr_en && full_c) begin
         overflow_d = 1'b1;
      end
      case ({push_c, pop_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Sequencer next-state: guard after reset, then pop/enable/wait/gap per byte
   always_comb begin
      state_d     = state_q;
      tx_enable_d = 1'b0;
      tx_data_d   = tx_data_q;
      guard_cnt_d = guard_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      unique case (state_q)
         ST_GUARD: begin
            if (tx_done || (guard_cnt_q == GUARD_W'(GUARD_LEN - 1))) begin
               state_d = ST_IDLE;
            end else begin
               guard_cnt_d = guard_cnt_q + GUARD_W'(1);
            end
         end
         ST_IDLE: begin
            if (pop_c) begin
               tx_enable_d = 1'b1;
               tx_data_d   = mem_q[rd_ptr_q];
               state_d     = ST_SEND;
            end
         end
         ST_SEND: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (tx_done) begin
               if (GAP_CYCLES > 0) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: begin
            state_d = ST_GUARD;
         end
      endcase
   end

   // FIFO storage; contents need no reset since pointers are cleared
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_GUARD;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         tx_enable_q <= 1'b0;
         tx_data_q   <= 8'h00;
         guard_cnt_q <= '0;
         gap_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         tx_enable_q <= tx_enable_d;
         tx_data_q   <= tx_data_d;
         guard_cnt_q <= guard_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
      end
   end

   // Status derived from registered count and state
   assign full      = full_c;
   assign empty     = (count_q == '0);
   assign busy      = (state_q != ST_IDLE) || (count_q != '0);
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign tx_enable = tx_enable_q;
   assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: two instances (no gap / 3-clock gap) each feeding a
// behavioural transmitter without reset; scoreboard queues hold accepted bytes.
module tb_uart_tx_feeder;

   localparam int unsigned DEPTH      = 4;
   localparam int unsigned CPB        = 4;
   localparam int          GUARD_CLKS = 10 * CPB + 2;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n0 = 1'b0, rst_n1 = 1'b0;
   logic       wr_en0 = 1'b0, wr_en1 = 1'b0;
   logic [7:0] wr_data0 = 8'h00, wr_data1 = 8'h00;
   logic       full0, empty0, overflow0, tx_enable0, tx_done0, busy0;
   logic       full1, empty1, overflow1, tx_enable1, tx_done1, busy1;
   logic [2:0] count0, count1;
   logic [7:0] tx_data0, tx_data1;
   logic       line0;

   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] exp_q [$];
   logic [7:0] exp_line_q [$];

   uart_tx_feeder #(.DEPTH(DEPTH), .CLK_PER_BIT(CPB), .GAP_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n0), .wr_en(wr_en0), .wr_data(wr_data0),
      .full(full0), .empty(empty0), .count(count0), .overflow(overflow0),
      .tx_enable(tx_enable0), .tx_data(tx_data0), .tx_done(tx_done0), .busy(busy0)
   );

   uart_tx_feeder #(.DEPTH(DEPTH), .CLK_PER_BIT(CPB), .GAP_CYCLES(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n1), .wr_en(wr_en1), .wr_data(wr_data1),
      .full(full1), .empty(empty1), .count(count1), .overflow(overflow1),
      .tx_enable(tx_enable1), .tx_data(tx_data1), .tx_done(tx_done1), .busy(busy1)
   );

   // Behavioural transmitters: latch on enable, 10 bits of CPB clocks, done pulse; never reset
   logic       x_busy [2] = '{1'b0, 1'b0};
   logic       x_done [2] = '{1'b0, 1'b0};
   logic [3:0] x_bit  [2] = '{4'd0, 4'd0};
   logic [1:0] x_cnt  [2] = '{2'd0, 2'd0};
   logic [9:0] x_sh   [2] = '{10'h3FF, 10'h3FF};

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         x_done[i] <= 1'b0;
         if (x_busy[i]) begin
            if (x_cnt[i] == 2'd3) begin
               x_cnt[i] <= 2'd0;
               if (x_bit[i] == 4'd9) begin
                  x_busy[i] <= 1'b0;
                  x_done[i] <= 1'b1;
               end else begin
                  x_bit[i] <= x_bit[i] + 4'd1;
               end
            end else begin
               x_cnt[i] <= x_cnt[i] + 2'd1;
            end
         end else if ((i == 0) ? tx_enable0 : tx_enable1) begin
            x_busy[i] <= 1'b1;
            x_bit[i]  <= 4'd0;
            x_cnt[i]  <= 2'd0;
            x_sh[i]   <= {1'b1, ((i == 0) ? tx_data0 : tx_data1), 1'b0};
         end
      end
   end

   assign tx_done0 = x_done[0];
   assign tx_done1 = x_done[1];
   assign line0    = x_busy[0] ? x_sh[0][x_bit[0]] : 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic sb_pop(input string tag, input logic [7:0] data, input logic prev_en);
      check_eq({tag, "_single_pulse"}, 32'(prev_en), 0);
      check_eq({tag, "_sb_pending"}, 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check_eq(tag, 32'(data), 32'(exp_q.pop_front()));
   endtask

   // Output monitor and serial receiver on instance 0's line, sampled on negedge
   logic       en0_prev = 1'b0, en1_prev = 1'b0;
   logic       rx_act = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_byte = 8'h00;

   always @(negedge clk) begin
      if (tx_enable0) sb_pop("tx_data0", tx_data0, en0_prev);
      if (tx_enable1) sb_pop("tx_data1", tx_data1, en1_prev);
      en0_prev = tx_enable0;
      en1_prev = tx_enable1;
      if (rx_act) begin
         rx_cnt++;
         if (rx_cnt % 4 == 2) begin
            if (rx_cnt / 4 == 0) begin
               check_eq("rx_start", 32'(line0), 0);
            end else if (rx_cnt / 4 <= 8) begin
               rx_byte = {line0, rx_byte[7:1]};
            end else begin
               check_eq("rx_stop", 32'(line0), 1);
               check_eq("rx_line_pending", 32'(exp_line_q.size() != 0), 1);
               if (exp_line_q.size() != 0)
                  check_eq("rx_byte", 32'(rx_byte), 32'(exp_line_q.pop_front()));
               rx_act = 1'b0;
            end
         end
      end else if (!line0) begin
         rx_act = 1'b1;
         rx_cnt = 0;
      end
   end

   function automatic logic sig_of(input int sel);
      case (sel)
         0:       return tx_enable0;
         1:       return tx_done0;
         2:       return tx_enable1;
         default: return tx_done1;
      endcase
   endfunction

   // Wait (bounded) for a DUT/transmitter strobe; returns the cycle stamp it was seen
   task automatic wait_sig(input int sel, input int budget, input string tag, output int at);
      logic seen;
      seen = 1'b0;
      at   = -1;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         if (sig_of(sel)) begin
            seen = 1'b1;
            at   = cyc;
         end
      end
      check_eq({tag, "_seen"}, 32'(seen), 1);
   endtask

   task automatic push(input int inst, input logic [7:0] b, input logic ok);
      if (inst == 0) begin
         wr_en0 = 1'b1; wr_data0 = b;
      end else begin
         wr_en1 = 1'b1; wr_data1 = b;
      end
      if (ok) begin
         exp_q.push_back(b);
         if (inst == 0) exp_line_q.push_back(b);
      end
      @(negedge clk);
      wr_en0 = 1'b0;
      wr_en1 = 1'b0;
   endtask

   task automatic reset0();
      rst_n0 = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int r, d, e;
      repeat (3) @(negedge clk);

      // Reset state
      check_eq("rst_count", 32'(count0), 0);
      check_eq("rst_empty", 32'(empty0), 1);
      check_eq("rst_full", 32'(full0), 0);
      check_eq("rst_overflow", 32'(overflow0), 0);
      check_eq("rst_tx_enable", 32'(tx_enable0), 0);
      check_eq("rst_tx_data", 32'(tx_data0), 0);
      check_eq("rst_busy", 32'(busy0), 1);

      // 1: single byte after guard expiry
      rst_n0 = 1'b1;
      r = cyc;
      push(0, 8'hA5, 1'b1);
      wait_sig(0, 60, "t1_en", e);
      check_eq("t1_guard_latency", 32'(e - r), 32'(GUARD_CLKS + 1));
      wait_sig(1, 60, "t1_done", d);
      check_eq("t1_data_hold", 32'(tx_data0), 32'h A5);

      // 2: three back-to-back bytes, enable two clocks after each done
      push(0, 8'h01, 1'b1);
      push(0, 8'h02, 1'b1);
      push(0, 8'h03, 1'b1);
      wait_sig(1, 60, "t2_done_a", d);
      for (int k = 0; k < 2; k++) begin
         wait_sig(0, 10, "t2_en", e);
         check_eq("t2_done_to_en", 32'(e - d), 2);
         wait_sig(1, 60, "t2_done", d);
      end
      check_eq("t2_empty", 32'(empty0), 1);

      // 3: fill during guard, fifth push dropped, overflow sticky
      reset0();
      check_eq("t3_rst_count", 32'(count0), 0);
      rst_n0 = 1'b1;
      push(0, 8'h10, 1'b1);
      push(0, 8'h11, 1'b1);
      push(0, 8'h12, 1'b1);
      check_eq("t3_full_at3", 32'(full0), 0);
      push(0, 8'h13, 1'b1);
      check_eq("t3_count4", 32'(count0), 4);
      check_eq("t3_full_at4", 32'(full0), 1);
      check_eq("t3_no_ovf_yet", 32'(overflow0), 0);
      push(0, 8'h14, 1'b0);
      check_eq("t3_count_after_drop", 32'(count0), 4);
      check_eq("t3_overflow", 32'(overflow0), 1);
      for (int k = 0; k < 4; k++) wait_sig(1, 120, "t3_done", d);
      check_eq("t3_overflow_sticky", 32'(overflow0), 1);
      check_eq("t3_drained", 32'(count0), 0);
      reset0();
      check_eq("t3_overflow_cleared", 32'(overflow0), 0);

      // 4: push on the pop edge at count 2, six pushes wrap the pointers
      rst_n0 = 1'b1;
      push(0, 8'h20, 1'b1);
      wait_sig(0, 60, "t4_en0", e);
      push(0, 8'h21, 1'b1);
      push(0, 8'h22, 1'b1);
      check_eq("t4_count2", 32'(count0), 2);
      wait_sig(1, 60, "t4_done0", d);
      @(negedge clk);
      push(0, 8'h23, 1'b1);
      check_eq("t4_same_edge_count", 32'(count0), 2);
      check_eq("t4_same_edge_en", 32'(tx_enable0), 1);
      push(0, 8'h24, 1'b1);
      push(0, 8'h25, 1'b1);
      check_eq("t4_count4", 32'(count0), 4);
      for (int k = 0; k < 5; k++) wait_sig(1, 60, "t4_done", d);
      check_eq("t4_drained", 32'(count0), 0);

      // 5: reset mid-frame; guard absorbs the unfinished frame
      push(0, 8'h3C, 1'b1);
      wait_sig(0, 10, "t5_en", e);
      repeat (10) @(negedge clk);
      reset0();
      check_eq("t5_rst_count", 32'(count0), 0);
      check_eq("t5_rst_en", 32'(tx_enable0), 0);
      check_eq("t5_rst_data", 32'(tx_data0), 0);
      rst_n0 = 1'b1;
      r = cyc;
      push(0, 8'hC3, 1'b1);
      wait_sig(1, 60, "t5_done_inflight", d);
      check_eq("t5_done_before_guard", 32'((d - r) < GUARD_CLKS), 1);
      wait_sig(0, 10, "t5_en_after", e);
      check_eq("t5_done_to_en", 32'(e - d), 2);
      wait_sig(1, 60, "t5_done_c3", d);

      // 6: GAP_CYCLES=3 instance
      rst_n1 = 1'b1;
      push(1, 8'h5A, 1'b1);
      push(1, 8'h96, 1'b1);
      check_eq("t6_full", 32'(full1), 0);
      wait_sig(2, 60, "t6_en0", e);
      wait_sig(3, 60, "t6_done0", d);
      wait_sig(2, 20, "t6_en1", e);
      check_eq("t6_gap_latency", 32'(e - d), 5);
      wait_sig(3, 60, "t6_done1", d);

      repeat (4) @(negedge clk);
      check_eq("end_busy0", 32'(busy0), 0);
      check_eq("end_busy1", 32'(busy1), 0);
      check_eq("end_empty1", 32'(empty1), 1);
      check_eq("end_count1", 32'(count1), 0);
      check_eq("end_overflow1", 32'(overflow1), 0);
      check_eq("end_sb_empty", 32'(exp_q.size()), 0);
      check_eq("end_line_sb_empty", 32'(exp_line_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
